// File: rtl/div_pkg.sv
// Shared definitions for the restoring shift-subtract divider sequencer.
//   DEFAULT_WIDTH : default operand width (and iteration count)
//   state_t       : sequencer state encoding
package div_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    // The values are fixed so that every code above StDone is an unused encoding.
    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StClr    = 4'd1,
        StLoad   = 4'd2,
        StShift0 = 4'd3,
        StSub    = 4'd4,
        StSettle = 4'd5,
        StDecide = 4'd6,
        StCheck  = 4'd7,
        StDone   = 4'd8
    } state_t;

    // True for the states in which a divide is in progress.
    function automatic logic is_busy_state(input state_t s);
        return (s == StClr) || (s == StLoad) || (s == StShift0) || (s == StSub) ||
               (s == StSettle) || (s == StDecide) || (s == StCheck);
    endfunction

endpackage

// File: rtl/divider_control.sv
// Sequencer for a restoring shift-subtract divider. It drives the controls of the
// remainder/quotient register and the add/sub select of the shared ALU. It runs WIDTH
// iterations of four cycles each and gives the CPU a start/busy/done handshake.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : divide request, sampled in idle/done only
//   divisor    : divisor, zero-checked when start is sampled
//   rem_msb    : sign bit of the remainder register (valid after the subtract)
//   rem_rst    : one-cycle clear pulse to the remainder register
//   wrctrl     : load {0, dividend} into the remainder register
//   alu_sub    : ALU select, 1 = remainder - divisor, 0 = remainder + divisor
//   ozctrl     : quotient bit; 1 = difference kept, 0 = restore
//   ready_wait : final iteration, the register shifts the remainder back right
//   ready      : result valid (same as done)
//   busy       : divide in progress
//   done       : divide finished; held until the next accepted start
//   dz_err     : divisor was zero; valid with done
//   iter       : current iteration index
module divider_control
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] divisor,
    input  logic             rem_msb,
    output logic             rem_rst,
    output logic             wrctrl,
    output logic             alu_sub,
    output logic             ozctrl,
    output logic             ready_wait,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             dz_err,
    output logic [CNT_W-1:0] iter
);

    state_t state_q;
    state_t state_d;

    logic last_iter;
    logic accept;
    logic div_zero;

    assign last_iter = (iter == CNT_W'(WIDTH - 1));
    assign accept    = start && ((state_q == StIdle) || (state_q == StDone));
    assign div_zero  = (divisor == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = div_zero ? StDone : StClr;
                end
            end
            StClr:    state_d = StLoad;
            StLoad:   state_d = StShift0;
            StShift0: state_d = StSub;
            StSub:    state_d = StSettle;
            StSettle: state_d = StDecide;
            StDecide: state_d = StCheck;
            StCheck:  state_d = last_iter ? StDone : StSub;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state, so each one is a clean Moore
    // output of the state register. The sign of the difference is captured straight
    // into ozctrl/alu_sub on the SETTLE -> DECIDE edge; that register is the "neg" latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            rem_rst    <= 1'b0;
            wrctrl     <= 1'b0;
            alu_sub    <= 1'b0;
            ozctrl     <= 1'b0;
            ready_wait <= 1'b0;
            ready      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dz_err     <= 1'b0;
            iter       <= '0;
        end else begin
            state_q    <= state_d;
            rem_rst    <= (state_d == StClr);
            wrctrl     <= (state_d == StLoad);
            // In DECIDE a negative difference selects add, restoring the remainder.
            alu_sub    <= (state_d == StSub) || (state_d == StSettle) ||
                          ((state_d == StDecide) && !rem_msb);
            ozctrl     <= (state_d == StDecide) && !rem_msb;
            // iter does not change between DECIDE and CHECK, so it is valid here.
            ready_wait <= (state_d == StCheck) && last_iter;
            ready      <= (state_d == StDone);
            done       <= (state_d == StDone);
            busy       <= is_busy_state(state_d);

            if (accept) begin
                dz_err <= div_zero;
            end

            if (state_q == StShift0) begin
                iter <= '0;
            end else if ((state_q == StCheck) && !last_iter) begin
                iter <= iter + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_divider_control.sv
// Directed bench for divider_control. Each DUT (WIDTH=32 and WIDTH=8) is paired with a
// behavioural remainder register and ALU, so quotient/remainder come out of the
// control sequence itself and are checked against hand-computed values.
module tb_divider_control;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // ---------------- WIDTH = 32 ----------------
    logic        start32 = 1'b0;
    logic [31:0] dvd32 = '0;
    logic [31:0] dvs32 = '0;
    logic        rem_msb32;
    logic        rem_rst32, wrctrl32, alu_sub32, ozctrl32, ready_wait32;
    logic        ready32, busy32, done32, dz_err32;
    logic [5:0]  iter32;

    divider_control #(.WIDTH(32)) dut32 (
        .clk        (clk),
        .rst        (rst),
        .start      (start32),
        .divisor    (dvs32),
        .rem_msb    (rem_msb32),
        .rem_rst    (rem_rst32),
        .wrctrl     (wrctrl32),
        .alu_sub    (alu_sub32),
        .ozctrl     (ozctrl32),
        .ready_wait (ready_wait32),
        .ready      (ready32),
        .busy       (busy32),
        .done       (done32),
        .dz_err     (dz_err32),
        .iter       (iter32)
    );

    logic [32:0] l32;
    logic [31:0] r32;
    logic [32:0] alu32;
    logic        act32;
    int          p32;

    assign alu32     = alu_sub32 ? (l32 - {1'b0, dvs32}) : (l32 + {1'b0, dvs32});
    assign rem_msb32 = l32[32];

    // Register model: shift after load, then per 4-cycle iteration:
    // capture difference, hold, keep/restore + shift in quotient bit, final right shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l32 <= '0; r32 <= '0; act32 <= 1'b0; p32 <= 0;
        end else if (rem_rst32) begin
            l32 <= '0; r32 <= '0; act32 <= 1'b0; p32 <= 0;
        end else if (wrctrl32) begin
            l32 <= '0; r32 <= dvd32; act32 <= 1'b1; p32 <= 0;
        end else if (act32) begin
            p32 <= p32 + 1;
            if (p32 == 0) begin
                {l32, r32} <= {l32, r32} << 1;
            end else begin
                case ((p32 - 1) % 4)
                    0: l32 <= alu32;
                    2: begin
                        if (ozctrl32) {l32, r32} <= {l32[31:0], r32, 1'b1};
                        else          {l32, r32} <= {alu32[31:0], r32, 1'b0};
                    end
                    3: begin
                        if (ready_wait32) begin
                            l32   <= l32 >> 1;
                            act32 <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- WIDTH = 8 ----------------
    logic       start8 = 1'b0;
    logic [7:0] dvd8 = '0;
    logic [7:0] dvs8 = '0;
    logic       rem_msb8;
    logic       rem_rst8, wrctrl8, alu_sub8, ozctrl8, ready_wait8;
    logic       ready8, busy8, done8, dz_err8;
    logic [3:0] iter8;

    divider_control #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .start      (start8),
        .divisor    (dvs8),
        .rem_msb    (rem_msb8),
        .rem_rst    (rem_rst8),
        .wrctrl     (wrctrl8),
        .alu_sub    (alu_sub8),
        .ozctrl     (ozctrl8),
        .ready_wait (ready_wait8),
        .ready      (ready8),
        .busy       (busy8),
        .done       (done8),
        .dz_err     (dz_err8),
        .iter       (iter8)
    );

    logic [8:0] l8;
    logic [7:0] r8;
    logic [8:0] alu8;
    logic       act8;
    int         p8;

    assign alu8     = alu_sub8 ? (l8 - {1'b0, dvs8}) : (l8 + {1'b0, dvs8});
    assign rem_msb8 = l8[8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l8 <= '0; r8 <= '0; act8 <= 1'b0; p8 <= 0;
        end else if (rem_rst8) begin
            l8 <= '0; r8 <= '0; act8 <= 1'b0; p8 <= 0;
        end else if (wrctrl8) begin
            l8 <= '0; r8 <= dvd8; act8 <= 1'b1; p8 <= 0;
        end else if (act8) begin
            p8 <= p8 + 1;
            if (p8 == 0) begin
                {l8, r8} <= {l8, r8} << 1;
            end else begin
                case ((p8 - 1) % 4)
                    0: l8 <= alu8;
                    2: begin
                        if (ozctrl8) {l8, r8} <= {l8[7:0], r8, 1'b1};
                        else         {l8, r8} <= {alu8[7:0], r8, 1'b0};
                    end
                    3: begin
                        if (ready_wait8) begin
                            l8   <= l8 >> 1;
                            act8 <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Counts cycles in which the WIDTH=32 register was cleared or loaded.
    int wr_evt = 0;
    always_ff @(posedge clk) begin
        if (wrctrl32 || rem_rst32) wr_evt <= wr_evt + 1;
    end

    // ---------------- checking helpers ----------------
    int vectors = 0;
    int errs    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after the edge that sampled start.
    task automatic go32(input logic [31:0] a, input logic [31:0] b);
        dvd32   = a;
        dvs32   = b;
        start32 = 1'b1;
        tick();
        start32 = 1'b0;
    endtask

    // Cycles from the start-sampling edge to the first edge with done high.
    // pulse_at > 0 raises start for the edge numbered pulse_at (while busy).
    task automatic wait32(input int pulse_at, output int cyc);
        cyc = 0;
        while (cyc < 400 && !done32) begin
            start32 = (cyc + 1 == pulse_at);
            tick();
            cyc++;
        end
        start32 = 1'b0;
    endtask

    logic [15:0] outs32;
    logic [11:0] outs8;
    assign outs32 = {rem_rst32, wrctrl32, alu_sub32, ozctrl32, ready_wait32, ready32,
                     busy32, done32, dz_err32, 1'b0, iter32};
    assign outs8  = {rem_rst8, wrctrl8, alu_sub8, ozctrl8, ready_wait8, ready8,
                     busy8, done8, dz_err8, 1'b0, iter8[1:0]};

    initial begin
        int cyc;
        int ev0;
        int rw_n;
        int rw_at;

        // ---- reset state ----
        #2 rst = 1'b1;
        #1;
        chk("reset_outs32", 64'(outs32), 64'h0);
        chk("reset_outs8", 64'({outs8, iter8}), 64'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("idle_outs32", 64'(outs32), 64'h0);

        // ---- 1: 100 / 7 ----
        go32(32'd100, 32'd7);
        chk("t1_busy_after_start", 64'({busy32, done32}), 64'b10);
        wait32(0, cyc);
        chk("t1_latency", 64'(cyc), 64'd131);
        chk("t1_quotient", 64'(r32), 64'd14);
        chk("t1_remainder", 64'(l32), 64'd2);
        chk("t1_flags", 64'({ready32, busy32, dz_err32}), 64'b100);
        chk("t1_iter_final", 64'(iter32), 64'd31);

        // ---- 2: divide by zero from DONE ----
        ev0 = wr_evt;
        go32(32'd55, 32'd0);
        chk("t2_dz_flags", 64'({done32, ready32, dz_err32, busy32}), 64'b1110);
        tick();
        tick();
        tick();
        chk("t2_no_reg_traffic", 64'(wr_evt - ev0), 64'd0);
        chk("t2_done_held", 64'({done32, dz_err32}), 64'b11);

        // ---- 3: start pulse while busy is ignored ----
        go32(32'd100, 32'd7);
        chk("t3_done_dz_cleared", 64'({done32, dz_err32, busy32}), 64'b001);
        wait32(50, cyc);
        chk("t3_latency", 64'(cyc), 64'd131);
        chk("t3_quotient", 64'(r32), 64'd14);
        chk("t3_remainder", 64'(l32), 64'd2);

        // ---- 4: reset mid-operation, then restart ----
        go32(32'd100, 32'd7);
        repeat (59) tick();
        chk("t4_busy_before_rst", 64'(busy32), 64'd1);
        rst = 1'b1;
        #1;
        chk("t4_rst_outs", 64'(outs32), 64'h0);
        tick();
        rst = 1'b0;
        go32(32'd100, 32'd7);
        wait32(0, cyc);
        chk("t4_latency", 64'(cyc), 64'd131);
        chk("t4_quotient", 64'(r32), 64'd14);
        chk("t4_remainder", 64'(l32), 64'd2);

        // ---- 5: all-ones / 1, then 5 / 9 started from DONE ----
        go32(32'hFFFF_FFFF, 32'd1);
        wait32(0, cyc);
        chk("t5a_latency", 64'(cyc), 64'd131);
        chk("t5a_quotient", 64'(r32), 64'hFFFF_FFFF);
        chk("t5a_remainder", 64'(l32), 64'd0);
        go32(32'd5, 32'd9);
        chk("t5b_done_drops", 64'({done32, ready32, busy32}), 64'b001);
        wait32(0, cyc);
        chk("t5b_latency", 64'(cyc), 64'd131);
        chk("t5b_quotient", 64'(r32), 64'd0);
        chk("t5b_remainder", 64'(l32), 64'd5);

        // ---- 6: WIDTH=8, 200 / 13 ----
        dvd8   = 8'd200;
        dvs8   = 8'd13;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        cyc   = 0;
        rw_n  = 0;
        rw_at = -1;
        while (cyc < 200 && !done8) begin
            tick();
            cyc++;
            if (ready_wait8) begin
                rw_n++;
                rw_at = cyc;
            end
        end
        chk("t6_latency", 64'(cyc), 64'd35);
        chk("t6_quotient", 64'(r8), 64'd15);
        chk("t6_remainder", 64'(l8), 64'd5);
        chk("t6_ready_wait_count", 64'(rw_n), 64'd1);
        chk("t6_ready_wait_cycle", 64'(rw_at), 64'd34);
        chk("t6_iter_final", 64'(iter8), 64'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
